// File: rtl/ds_pattern_tx_if.sv
// Data-stream tx handshake bundle between the pattern transmitter and a NAP wrapper.
interface ds_pattern_tx_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  sop;
  logic                  eop;

  modport master (
    output valid,
    output data,
    output addr,
    output sop,
    output eop,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  addr,
    input  sop,
    input  eop,
    output ready
  );

endinterface

// File: rtl/ds_pattern_tx.sv
// Periodic multi-beat pattern message transmitter driving a NAP data-stream tx side.
// Each beat carries {seq, beat index, pattern} in its low 32 bits; higher bits are zero.
module ds_pattern_tx #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned PERIOD     = 25_000_000,
  parameter int unsigned MSG_BEATS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_dest_addr,
  ds_pattern_tx_if.master       tx,
  output logic [15:0]           o_msg_count,
  output logic                  o_busy
);

  localparam int unsigned TIMER_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BEAT_W    = 8;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned PAT_W     = 8;
  localparam int unsigned PAYLOAD_W = SEQ_W + BEAT_W + PAT_W;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(PERIOD - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT    = BEAT_W'(MSG_BEATS - 1);
  localparam logic [PAT_W-1:0]   PAT_RESET    = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [PAT_W-1:0]      pat_q, pat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  valid_q;
  logic                  busy_q;
  logic                  sop_q;
  logic                  eop_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  send_d;
  logic                  sop_d;
  logic                  eop_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  accept;

  // Next pattern byte for the selected advance mode.
  function automatic logic [PAT_W-1:0] advance(input logic [PAT_W-1:0] p,
                                               input logic [1:0]       m);
    logic [PAT_W-1:0] r;
    r = p;
    case (m)
      2'd0:    r = p + PAT_W'(1);
      2'd1:    r = (p == '0) ? PAT_RESET : {p[PAT_W-2:0], p[PAT_W-1]};
      2'd2:    r = (p == 8'h55) ? 8'hAA : 8'h55;
      default: r = ~p;
    endcase
    return r;
  endfunction

  assign accept = valid_q & tx.ready;

  // Next-state, counters and the payload for the beat presented after the next edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beat_d  = beat_q;
    seq_d   = seq_q;
    pat_d   = pat_q;
    addr_d  = addr_q;
    send_d  = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    data_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_COUNT;
          timer_d = TIMER_RELOAD;
        end
      end

      ST_COUNT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_SEND;
          beat_d  = '0;
          addr_d  = i_dest_addr;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_SEND: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            seq_d  = seq_q + SEQ_W'(1);
            pat_d  = advance(pat_q, i_mode);
            beat_d = '0;
            if (i_enable) begin
              state_d = ST_COUNT;
              timer_d = TIMER_RELOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stalled beats recompute identical fields, so outputs stay stable under backpressure.
    send_d = (state_d == ST_SEND);
    if (send_d) begin
      sop_d  = (beat_d == '0);
      eop_d  = (beat_d == LAST_BEAT);
      data_d = DATA_WIDTH'(PAYLOAD_W'({seq_d, beat_d, pat_d}));
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      beat_q  <= '0;
      seq_q   <= '0;
      pat_q   <= PAT_RESET;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
      seq_q   <= seq_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      valid_q <= send_d;
      busy_q  <= send_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
    end
  end

  assign tx.valid    = valid_q;
  assign tx.data     = data_q;
  assign tx.addr     = addr_q;
  assign tx.sop      = sop_q;
  assign tx.eop      = eop_q;
  assign o_msg_count = seq_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_ds_pattern_tx.sv
// Self-checking bench for ds_pattern_tx: message-level model plus directed literal checks.
module tb_ds_pattern_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned MB = 2;

  logic          clk;
  logic          reset;
  logic          en;
  logic [1:0]    mode;
  logic [AW-1:0] dest;
  logic [15:0]   msg_count;
  logic          busy;

  ds_pattern_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tx ();

  ds_pattern_tx #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PERIOD    (P),
    .MSG_BEATS (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (en),
    .i_mode     (mode),
    .i_dest_addr(dest),
    .tx         (tx),
    .o_msg_count(msg_count),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: is a message on the wire, how long until the next one, which beat.
  bit          m_rst;
  bit          m_send;
  int          m_wait;
  int          m_beat;
  logic [15:0] m_seq;
  logic [7:0]  m_pat;
  logic [AW-1:0] m_addr;

  logic [7:0]  got_pat[$];
  logic [15:0] got_seq[$];
  bit          prev_vs;

  function automatic logic [7:0] next_pat(input logic [7:0] p, input logic [1:0] m);
    case (m)
      2'd0:    return p + 8'd1;
      2'd1:    return (p == 8'h00) ? 8'h01 : ((p == 8'h80) ? 8'h01 : p * 2);
      2'd2:    return (p == 8'h55) ? 8'hAA : 8'h55;
      default: return 8'hFF - p;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_rst = reset;
    if (reset) begin
      m_send = 0; m_wait = -1; m_beat = 0; m_seq = 16'h0000; m_pat = 8'h01; m_addr = '0;
    end else if (m_send) begin
      if (tx.ready) begin
        if (m_beat == int'(MB) - 1) begin
          m_seq  = m_seq + 16'd1;
          m_pat  = next_pat(m_pat, mode);
          m_send = 0;
          m_beat = 0;
          m_wait = en ? int'(P) - 1 : -1;
        end else begin
          m_beat = m_beat + 1;
        end
      end
    end else if (m_wait < 0) begin
      if (en) m_wait = int'(P) - 1;
    end else if (!en) begin
      m_wait = -1;
    end else if (m_wait == 0) begin
      m_send = 1; m_beat = 0; m_addr = dest; m_wait = -1;
    end else begin
      m_wait = m_wait - 1;
    end
  endtask

  task automatic compare();
    if (m_rst) begin
      check("rst_valid", 64'(tx.valid), 64'd0);
      check("rst_busy",  64'(busy),     64'd0);
      check("rst_sop",   64'(tx.sop),   64'd0);
      check("rst_eop",   64'(tx.eop),   64'd0);
      check("rst_data",  tx.data,       64'd0);
      check("rst_addr",  64'(tx.addr),  64'd0);
      check("rst_count", 64'(msg_count), 64'd0);
    end else begin
      check("valid", 64'(tx.valid), 64'(m_send));
      check("busy",  64'(busy),     64'(m_send));
      check("count", 64'(msg_count), 64'(m_seq));
      if (m_send) begin
        check("data", tx.data, {32'h0, m_seq, 8'(m_beat), m_pat});
        check("addr", 64'(tx.addr), 64'(m_addr));
        check("sop",  64'(tx.sop), 64'(m_beat == 0));
        check("eop",  64'(tx.eop), 64'(m_beat == int'(MB) - 1));
      end
    end
    if (tx.valid && tx.sop && !prev_vs) begin
      got_pat.push_back(tx.data[7:0]);
      got_seq.push_back(tx.data[31:16]);
    end
    prev_vs = tx.valid && tx.sop;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!tx.valid && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(tx.valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    en = 1'b0;
    while (tx.valid && n < 20) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  task automatic restart(input logic [1:0] md);
    reset = 1'b1;
    en    = 1'b0;
    step();
    step();
    reset = 1'b0;
    got_pat.delete();
    got_seq.delete();
    mode = md;
    en   = 1'b1;
  endtask

  task automatic run_msgs(input int n, input int sw_at, input logic [1:0] sw_mode);
    int budget = 40 * n;
    while (got_pat.size() < n && budget > 0) begin
      step();
      budget--;
      if (got_pat.size() == sw_at) mode = sw_mode;
    end
    check("msg_budget", 64'(got_pat.size()), 64'(n));
    drain();
  endtask

  task automatic check_pats(input string name, input logic [7:0] exp[], input int n);
    for (int i = 0; i < n; i++) begin
      if (i < got_pat.size()) check(name, 64'(got_pat[i]), 64'(exp[i]));
      else check(name, 64'hDEAD, 64'(exp[i]));
    end
  endtask

  initial begin
    int lat;
    int beats;
    logic [7:0] exp_m1[];
    logic [7:0] exp_m3[];
    logic [7:0] exp_m2[];

    reset = 1'b1; en = 1'b1; mode = 2'd0; dest = 4'hA; tx.ready = 1'b1;
    prev_vs = 0;

    // Reset held four cycles with enable high: everything stays zero.
    repeat (4) step();
    reset = 1'b0;

    // Start latency and first message contents.
    lat = 0;
    while (!tx.valid && lat < 20) begin
      step();
      lat++;
    end
    check("start_latency", 64'(lat), 64'd5);
    check("beat0_data", 64'(tx.data[31:0]), 64'h0000_0001);
    check("beat0_sop",  64'(tx.sop), 64'd1);
    step();
    check("beat1_data", 64'(tx.data[31:0]), 64'h0000_0101);
    check("beat1_eop",  64'(tx.eop), 64'd1);
    step();
    check("count_after_msg1", 64'(msg_count), 64'd1);

    // Backpressure on beat0 of message 2; destination change must not leak in.
    wait_valid("msg2_valid", 20);
    tx.ready = 1'b0;
    dest     = 4'h5;
    for (int i = 0; i < 4; i++) begin
      check("stall_data", 64'(tx.data[31:0]), 64'h0001_0002);
      check("stall_addr", 64'(tx.addr), 64'hA);
      check("stall_sop",  64'(tx.sop), 64'd1);
      if (i < 3) step();
    end
    tx.ready = 1'b1;
    step();
    check("stall_beat1", 64'(tx.data[31:0]), 64'h0001_0102);
    step();
    check("count_after_msg2", 64'(msg_count), 64'd2);
    drain();

    // Pattern advance modes.
    exp_m1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    restart(2'd1);
    run_msgs(9, -1, 2'd1);
    check_pats("mode1_pat", exp_m1, 9);

    exp_m3 = '{8'h01, 8'hFE, 8'h01, 8'hFE, 8'hFF, 8'h00};
    restart(2'd3);
    run_msgs(6, 4, 2'd0);
    check_pats("mode3_mode0_pat", exp_m3, 6);

    exp_m2 = '{8'h01, 8'h55, 8'hAA, 8'h55};
    restart(2'd2);
    run_msgs(4, -1, 2'd2);
    check_pats("mode2_pat", exp_m2, 4);

    // Enable dropped during beat0: message completes, then nothing more.
    restart(2'd0);
    wait_valid("drop_valid", 20);
    en = 1'b0;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx.valid) beats++;
      step();
    end
    check("drop_beats", 64'(beats), 64'(MB));
    check("drop_count", 64'(msg_count), 64'd1);

    // Enable dropped during COUNT: back to idle, sequence untouched.
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    check("count_drop_busy", 64'(busy), 64'd0);
    check("count_drop_seq",  64'(msg_count), 64'd1);
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx.valid) beats++;
    end
    check("count_drop_quiet", 64'(beats), 64'd0);

    // Sequence wrap via a preloaded counter.
    force dut.seq_q = 16'hFFFF;
    m_seq = 16'hFFFF;
    #1;
    release dut.seq_q;
    got_pat.delete();
    got_seq.delete();
    en = 1'b1;
    begin
      int budget = 100;
      while (got_seq.size() < 2 && budget > 0) begin
        step();
        budget--;
      end
    end
    check("wrap_count_mid", 64'(msg_count), 64'd0);
    if (got_seq.size() == 2) begin
      check("wrap_seq0", 64'(got_seq[0]), 64'hFFFF);
      check("wrap_seq1", 64'(got_seq[1]), 64'h0000);
    end else begin
      check("wrap_msgs", 64'(got_seq.size()), 64'd2);
    end
    drain();
    check("wrap_count_end", 64'(msg_count), 64'd1);

    // Reset while a beat is stalled: abandon it, restart cleanly.
    tx.ready = 1'b0;
    en = 1'b1;
    wait_valid("midrst_valid", 20);
    step();
    reset = 1'b1;
    step();
    check("midrst_valid_low", 64'(tx.valid), 64'd0);
    reset = 1'b0;
    tx.ready = 1'b1;
    wait_valid("midrst_restart", 20);
    check("midrst_data", 64'(tx.data[31:0]), 64'h0000_0001);
    check("midrst_sop",  64'(tx.sop), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
